phone_dialer: RTL

PHONE_DIALER -- requirements
Module: phone_dialer

---
 rtl/dialer_pkg.sv | 25 ++
 rtl/tone_gen.sv | 30 +++
 rtl/phone_dialer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dialer_pkg.sv
// Shared types and constants for the DTMF-style phone dialer: FSM states,
// number geometry and default timing.
package dialer_pkg;

  localparam int NDIG    = 11;
  localparam int DIGIT_W = 4;
  localparam int SR_W    = NDIG * DIGIT_W;

  localparam int TONE_CYC_DEF = 5_000_000;
  localparam int GAP_CYC_DEF  = 2_500_000;
  localparam int BASE_HP_DEF  = 25_000;
  localparam int STEP_HP_DEF  = 2_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every half_period cycles while en is high,
// cleared to 0 with the counter restarted whenever en is low.
module tone_gen #(
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [HP_W-1:0] half_period,
  output logic            tone
);

  logic [HP_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == half_period - HP_W'(1)) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/phone_dialer.sv
// Dials an 11-digit BCD number: per digit a tone window then a silent gap,
// with abort, non-BCD error detection and a done pulse. All outputs are flops.
module phone_dialer
  import dialer_pkg::*;
#(
  parameter int TONE_CYC = TONE_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF,
  parameter int BASE_HP  = BASE_HP_DEF,
  parameter int STEP_HP  = STEP_HP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [43:0] phone_number,
  output logic [3:0]  digit,
  output logic [3:0]  digit_idx,
  output logic        tone_on,
  output logic        tone_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int MAX_CYC = (TONE_CYC > GAP_CYC) ? TONE_CYC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
  localparam int HP_W    = (BASE_HP < 2) ? 1 : $clog2(BASE_HP + 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  dur, dur_n;
  logic [SR_W-1:0]   sh, sh_n;
  logic [3:0]        digit_n, idx_n;
  logic              tone_on_n, busy_n, done_n, err_n;
  logic [HP_W-1:0]   half_period;

  // Handshake: start is a one-cycle request, accepted only in IDLE with abort low;
  // abort is a level that wins over everything else at the next edge.
  always_comb begin
    state_n = state;
    dur_n   = dur;
    sh_n    = sh;
    digit_n = digit;
    idx_n   = digit_idx;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          sh_n    = phone_number;
          idx_n   = 4'd0;
          digit_n = phone_number[SR_W-1 -: DIGIT_W];
          dur_n   = '0;
          if (is_bcd(phone_number[SR_W-1 -: DIGIT_W])) state_n = ST_TONE;
          else err_n = 1'b1;
        end
      end
      ST_TONE: begin
        if (dur == CNT_W'(TONE_CYC - 1)) begin
          dur_n   = '0;
          state_n = ST_GAP;
        end else begin
          dur_n = dur + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (dur == CNT_W'(GAP_CYC - 1)) begin
          dur_n = '0;
          if (digit_idx == 4'(NDIG - 1)) begin
            state_n = ST_FIN;
          end else begin
            // The next digit is checked here so a bad digit never gets a tone window.
            sh_n    = {sh[SR_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
            idx_n   = digit_idx + 4'd1;
            digit_n = sh[SR_W-DIGIT_W-1 -: DIGIT_W];
            if (is_bcd(sh[SR_W-DIGIT_W-1 -: DIGIT_W])) begin
              state_n = ST_TONE;
            end else begin
              state_n = ST_IDLE;
              err_n   = 1'b1;
            end
          end
        end else begin
          dur_n = dur + CNT_W'(1);
        end
      end
      ST_FIN: begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    if (abort && state != ST_IDLE) begin
      state_n = ST_IDLE;
      dur_n   = '0;
      sh_n    = sh;
      digit_n = digit;
      idx_n   = digit_idx;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end

    tone_on_n = (state_n == ST_TONE);
    busy_n    = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dur       <= '0;
      sh        <= '0;
      digit     <= 4'd0;
      digit_idx <= 4'd0;
      tone_on   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      dur       <= dur_n;
      sh        <= sh_n;
      digit     <= digit_n;
      digit_idx <= idx_n;
      tone_on   <= tone_on_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  assign half_period = HP_W'(BASE_HP - STEP_HP * int'(digit));

  // Enabled only while a tone window continues, so the wave restarts at 0 on
  // entry and is already cleared in the first cycle after the window.
  tone_gen #(.HP_W(HP_W)) u_tone_gen (
    .clk         (clk),
    .rst         (reset),
    .en          (tone_on & tone_on_n),
    .half_period (half_period),
    .tone        (tone_out)
  );

endmodule
